// File: rtl/serial_byte_assembler.sv
// serial_byte_assembler: collects a serial bit stream into WIDTH-bit words.
// Each finished word is handed to a separate output register that has a
// valid/ready handshake, so the next word can be assembled while the current
// one waits to be taken.
// Optional feature macro: PARITY_CHECK_EN. When it is defined, every frame
// carries one trailing even-parity bit. That bit is checked and reported on
// o_perr but is not stored in o_a.
module serial_byte_assembler #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_a,
  input  logic             i_a_vld,
  output logic             o_a_rdy,
  output logic [WIDTH-1:0] o_a,
  output logic             o_a_vld,
  input  logic             i_a_rdy,
  output logic             o_perr
);

`ifdef PARITY_CHECK_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST   = CW'(FRAME - 1);
  localparam logic [CW-1:0] FULL   = CW'(FRAME);
  localparam logic [CW-1:0] DATA_N = CW'(WIDTH);

  typedef enum logic {SHIFT, STALL} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg, sh_nxt;
  logic             accept, last, ld_shift, ld_stall, consume;

  assign accept  = o_a_rdy & i_a_vld;
  assign last    = accept & (cnt == LAST);
  assign consume = o_a_vld & i_a_rdy;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= SHIFT;
    else       state <= state_nxt;
  end

  // Next state, plus the strobes that load the output register.
  // ld_shift loads straight from the final frame bit.
  // ld_stall loads a word that was parked in the shift register.
  always_comb begin
    state_nxt = state;
    o_a_rdy   = 1'b0;
    ld_shift  = 1'b0;
    ld_stall  = 1'b0;
    case (state)
      SHIFT: begin
        o_a_rdy = 1'b1;
        if (i_a_vld && cnt == LAST) begin
          if (!o_a_vld || i_a_rdy) ld_shift  = 1'b1;
          else                     state_nxt = STALL;
        end
      end
      STALL: begin
        if (i_a_rdy) begin
          ld_stall  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      default: state_nxt = SHIFT;
    endcase
  end

  // Shift-register value after taking i_a.
  // A parity bit (position >= WIDTH) leaves the data unchanged.
  always_comb begin
    sh_nxt = sreg;
    if (cnt < DATA_N) begin
      if (MSB_FIRST) sh_nxt = {sreg[WIDTH-2:0], i_a};
      else           sh_nxt = {i_a, sreg[WIDTH-1:1]};
    end
  end

  // Bit counter and shift register.
  // A completed frame that cannot be handed off is held with cnt == FULL.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt  <= '0;
      sreg <= '0;
    end else if (ld_stall || (accept && ld_shift)) begin
      cnt  <= '0;
      sreg <= '0;
    end else if (last) begin
      cnt  <= FULL;
      sreg <= sh_nxt;
    end else if (accept) begin
      cnt  <= cnt + CW'(1);
      sreg <= sh_nxt;
    end
  end

  // Output register: a load takes priority over the consume clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_a     <= '0;
      o_a_vld <= 1'b0;
    end else if (ld_shift) begin
      o_a     <= sh_nxt;
      o_a_vld <= 1'b1;
    end else if (ld_stall) begin
      o_a     <= sreg;
      o_a_vld <= 1'b1;
    end else if (consume) begin
      o_a_vld <= 1'b0;
    end
  end

`ifdef PARITY_CHECK_EN
  logic par, perr_q;

  // par is the running XOR of every accepted bit in the current frame.
  // The trailing parity bit is included, so an even-parity frame XORs to 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      par    <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (ld_stall || (accept && ld_shift)) par <= 1'b0;
      else if (accept)                      par <= par ^ i_a;
      if (ld_shift)      perr_q <= par ^ i_a;
      else if (ld_stall) perr_q <= par;
      else if (consume)  perr_q <= 1'b0;
    end
  end

  assign o_perr = perr_q;
`else
  assign o_perr = 1'b0;
`endif

endmodule

// File: tb/tb_serial_byte_assembler.sv
// Bench for serial_byte_assembler. One stimulus stream drives an LSB-first
// instance and an MSB-first instance. A queue-based frame model predicts
// the outputs of both instances, and literal checks pin known words.
module tb_serial_byte_assembler;
  localparam int W = 8;
`ifdef PARITY_CHECK_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0, rst = 1'b1, a = 1'b0, a_vld = 1'b0, a_rdy = 1'b0;
  logic         rdy_l, rdy_m, vld_l, vld_m, perr_l, perr_m;
  logic [W-1:0] oa_l, oa_m;

  always #5 clk = ~clk;

  serial_byte_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(clk), .i_rst(rst), .i_a(a), .i_a_vld(a_vld), .o_a_rdy(rdy_l),
    .o_a(oa_l), .o_a_vld(vld_l), .i_a_rdy(a_rdy), .o_perr(perr_l));

  serial_byte_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(clk), .i_rst(rst), .i_a(a), .i_a_vld(a_vld), .o_a_rdy(rdy_m),
    .o_a(oa_m), .o_a_vld(vld_m), .i_a_rdy(a_rdy), .o_perr(perr_m));

  int checks = 0, errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model. q collects the accepted bits of the frame being built.
  // A full q is a finished frame waiting for the output register to free up.
  bit           q[$];
  bit           m_vld, m_perr, started;
  logic [W-1:0] m_wl, m_wm;

  always @(posedge clk) begin
    bit cons;
    if (rst) begin
      q.delete();
      m_vld = 0; m_perr = 0; m_wl = '0; m_wm = '0; started = 1;
    end else begin
      cons = m_vld && a_rdy;
      if (q.size() < FRAME && a_vld) q.push_back(a);
      if (q.size() == FRAME && (!m_vld || cons)) begin
        for (int i = 0; i < W; i++) begin
          m_wl[i]       = q[i];
          m_wm[W-1-i]   = q[i];
        end
        m_perr = 0;
`ifdef PARITY_CHECK_EN
        foreach (q[i]) m_perr = m_perr ^ q[i];
`endif
        q.delete();
        m_vld = 1;
      end else if (cons) begin
        m_vld  = 0;
        m_perr = 0;
      end
    end
  end

  // Compare both instances against the model every cycle
  always @(negedge clk) begin
    if (started) begin
      chk("rdy_lsb", rdy_l, q.size() != FRAME);
      chk("rdy_msb", rdy_m, q.size() != FRAME);
      chk("vld_lsb", vld_l, m_vld);
      chk("vld_msb", vld_m, m_vld);
      chk("perr_lsb", perr_l, m_vld ? m_perr : 1'b0);
      chk("perr_msb", perr_m, m_vld ? m_perr : 1'b0);
      if (m_vld) begin
        chk("word_lsb", oa_l, m_wl);
        chk("word_msb", oa_m, m_wm);
      end
    end
  end

  task automatic step(bit b, bit v);
    a = b; a_vld = v;
    @(posedge clk); #1;
  endtask

  task automatic send_word(logic [W-1:0] x, bit flip);
    for (int i = 0; i < W; i++) step(x[i], 1'b1);
`ifdef PARITY_CHECK_EN
    step((^x) ^ flip, 1'b1);
`endif
  endtask

  initial begin
    logic [W-1:0] x;
    step(0, 0); step(0, 0);
    rst = 1'b0;
    a_rdy = 1'b1;
    // reset mid-frame discards the partial word
    step(1, 1); step(1, 1); step(1, 1);
    rst = 1'b1;
    step(0, 0); step(0, 0);
    rst = 1'b0;
    chk("rst_oa", oa_l, 8'h00);
    chk("rst_vld", vld_l, 1'b0);
    chk("rst_rdy", rdy_l, 1'b1);
    send_word(8'h96, 1'b0);
    chk("fresh_lsb", oa_l, 8'h96);
    chk("fresh_msb", oa_m, 8'h69);
    step(0, 0);
    // LSB-first and MSB-first: 1,0,1,0,0,1,0,1
    send_word(8'hA5, 1'b0);
    chk("t2_lsb", oa_l, 8'hA5);
    chk("t2_msb", oa_m, 8'hA5);
    chk("t2_vld", vld_l, 1'b1);
    chk("t2_perr", perr_l, 1'b0);
    step(0, 0);
    chk("t2_vld_drop", vld_l, 1'b0);
    // 1,1,0,0,0,0,0,0
    send_word(8'h03, 1'b0);
    chk("t3_msb", oa_m, 8'hC0);
    chk("t3_lsb", oa_l, 8'h03);
    step(0, 0);
    // back-pressure
    a_rdy = 1'b0;
    send_word(8'h3C, 1'b0);
    chk("t4_first", oa_l, 8'h3C);
    send_word(8'h81, 1'b0);
    chk("t4_held", oa_l, 8'h3C);
    chk("t4_stall_rdy", rdy_l, 1'b0);
    a_rdy = 1'b1;
    step(0, 0);
    a_rdy = 1'b0;
    chk("t4_second", oa_l, 8'h81);
    chk("t4_vld", vld_l, 1'b1);
    chk("t4_rdy", rdy_l, 1'b1);
    step(0, 0);
    chk("t4_hold2", oa_l, 8'h81);
    a_rdy = 1'b1;
    step(0, 0);
    // bubbles between every bit
    x = 8'h5A;
    for (int i = 0; i < W; i++) begin
      step(x[i], 1'b1);
      if (i < W - 1) step(0, 0);
    end
`ifdef PARITY_CHECK_EN
    step(0, 0);
    step(^x, 1'b1);
`endif
    chk("t5_word", oa_l, 8'h5A);
    chk("t5_vld", vld_l, 1'b1);
    step(0, 0);
    chk("t5_no_extra", vld_l, 1'b0);
`ifdef PARITY_CHECK_EN
    send_word(8'hA5, 1'b0);
    chk("t6_good_perr", perr_l, 1'b0);
    chk("t6_good_word", oa_l, 8'hA5);
    step(0, 0);
    send_word(8'hA5, 1'b1);
    chk("t6_bad_perr", perr_l, 1'b1);
    chk("t6_bad_word", oa_l, 8'hA5);
    step(0, 0);
`endif
    // randomized traffic with back-pressure and occasional resets
    repeat (4000) begin
      a_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) a_rdy = 1'b0;
      rst = ($urandom_range(0, 249) == 0);
      step($urandom_range(0, 1), $urandom_range(0, 9) < 7);
    end
    rst = 1'b0;
    step(0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
